// File: rtl/shifter_iter.sv
// shifter_iter: iterative shifter/rotator resolving one shift-amount bit per clock.
module shifter_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);
    localparam logic [5:0] SLL = 6'b000010;
    localparam logic [5:0] SRL = 6'b000011;
    localparam logic [5:0] SRA = 6'b000100;
    localparam logic [5:0] ROL = 6'b000101;
    localparam logic [5:0] ROR = 6'b000110;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_out;
    logic [SHAMT_W-1:0] r_shamt;
    logic [SHAMT_W-1:0] r_cnt;
    logic [5:0]         r_op;
    logic               r_fill;
    logic               r_done;
    logic [SHAMT_W-1:0] w_amt;
    logic [SHAMT_W-1:0] w_inv;
    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_next;
    logic               w_legal;
    logic               w_unused;
    // w_amt is both the stage distance 2^cnt and the one-hot mask selecting shamt[cnt];
    // w_inv is WIDTH-2^cnt, which always fits since 2^cnt lies in [1, WIDTH/2].
    always_comb begin
        w_amt   = SHAMT_W'(1) << r_cnt;
        w_inv   = SHAMT_W'(0) - w_amt;
        w_step  = (r_op == SLL) ? r_work << w_amt :
                  (r_op == SRL) ? r_work >> w_amt :
                  (r_op == SRA) ? (r_work >> w_amt) | (~({WIDTH{1'b1}} >> w_amt) & {WIDTH{r_fill}}) :
                  (r_op == ROL) ? (r_work << w_amt) | (r_work >> w_inv) :
                  (r_op == ROR) ? (r_work >> w_amt) | (r_work << w_inv) : r_work;
        w_next  = |(r_shamt & w_amt) ? w_step : r_work;
        w_legal = (r_op >= SLL) && (r_op <= ROR);
    end
    assign w_unused = ^dataB[WIDTH-1:SHAMT_W];
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_out   <= '0;
            r_shamt <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_fill  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_work  <= dataA;
                    r_shamt <= dataB[SHAMT_W-1:0];
                    r_op    <= Signal;
                    r_fill  <= dataA[WIDTH-1];
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
            end else begin
                r_work <= w_next;
                r_cnt  <= r_cnt + 1'b1;
                if (r_cnt == SHAMT_W'(SHAMT_W - 1)) begin
                    r_out   <= w_legal ? w_next : '0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            end
        end
    end
    assign busy    = (r_state == SHIFT);
    assign done    = r_done;
    assign dataOut = r_out;
endmodule

// File: tb/tb_shifter_iter.sv
// tb_shifter_iter: randomized and directed checks of shifter_iter against a behavioural model.
module tb_shifter_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;
    int          n_checks = 0;
    int          n_fail   = 0;

    shifter_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
        .Signal(Signal), .busy(busy), .done(done), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            6'b000010: return a << n;
            6'b000011: return a >> n;
            6'b000100: return $signed(a) >>> n;
            6'b000101: return (n == 0) ? a : (a << n) | (a >> (32 - n));
            6'b000110: return (n == 0) ? a : (a >> n) | (a << (32 - n));
            default:   return 32'h0;
        endcase
    endfunction

    // Called #1 after an edge with the DUT idle; inputs are scrambled while busy.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          cyc;
        exp    = ref_model(op, a, b);
        Signal = op;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = 6'($urandom);
        cyc    = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 32'd5);
        check("busy_in_done", 32'(busy), 32'd0);
        check("result", dataOut, exp);
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done), 32'd0);
        check("result_held", dataOut, exp);
    endtask

    initial begin
        logic [5:0]  ops [6] = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110, 6'b111111};
        logic [31:0] v, junk;
        int          seen;
        reset  = 1'b0;
        start  = 1'b1;
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = 6'b000010;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dataOut", dataOut, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(6'b000010, 32'h00000001, 32'd31);
        run_op(6'b000100, 32'h800000F0, 32'h00000024);
        run_op(6'b000011, 32'h800000F0, 32'h00000024);
        run_op(6'b000110, 32'h000000F1, 32'd4);
        run_op(6'b000101, 32'h80000001, 32'd1);
        run_op(6'b000010, 32'hA5A5_1234, 32'd0);
        run_op(6'b111111, 32'hFFFFFFFF, 32'd3);
        check("spec_sra", ref_model(6'b000100, 32'h800000F0, 32'h24), 32'hF800000F);

        for (int i = 0; i < 40; i++)
            run_op(ops[$urandom_range(5)], $urandom, $urandom);

        // Back-to-back: start held high, each op accepted on the edge of the previous done.
        Signal = 6'b000010;
        dataB  = 32'd1;
        start  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v     = $urandom;
            dataA = v;
            @(posedge clk); #1;
            check("b2b_busy", 32'(busy), 32'd1);
            junk  = $urandom;
            dataA = junk;
            repeat (4) @(posedge clk);
            #1;
            check("b2b_no_early_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_result", dataOut, v << 1);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the third SHIFT cycle aborts the operation silently.
        run_op(6'b000101, 32'h12345678, 32'd7);
        Signal = 6'b000011;
        dataA  = 32'hDEADBEEF;
        dataB  = 32'd5;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dataOut", dataOut, 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 32'd0);
        run_op(6'b000011, 32'hDEADBEEF, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
